// File: rtl/reg_dest_scoreboard.sv
// reg_dest_scoreboard: tracks in-flight register writes from issue to write-back and raises the decode stall
module reg_dest_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_wr_en,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [ADDR_W-1:0]    issue_rs,
  input  logic [ADDR_W-1:0]    issue_rt,
  input  logic                 issue_use_rs,
  input  logic                 issue_use_rt,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rd,
  output logic                 stall,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 err
);
  localparam int N = 2**ADDR_W;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] r_cnt [N];
  logic [CNT_W-1:0] w_nxt [N];
  logic [N-1:0] r_busy, w_busy_nxt, w_inc_oh, w_dec_oh;
  logic r_err;
  logic w_rs_hit, w_rt_hit, w_full, w_inc, w_dec, w_ill;
  // a source retiring this cycle with its last pending write is forwarded from write-back
  assign w_rs_hit = issue_rs != '0 && r_cnt[issue_rs] != '0 &&
                    !(WB_BYPASS && wb_valid && wb_rd == issue_rs && r_cnt[issue_rs] == ONE);
  assign w_rt_hit = issue_rt != '0 && r_cnt[issue_rt] != '0 &&
                    !(WB_BYPASS && wb_valid && wb_rd == issue_rt && r_cnt[issue_rt] == ONE);
  // a saturated destination may still issue when the same register retires this cycle
  assign w_full   = issue_wr_en && issue_rd != '0 && r_cnt[issue_rd] == MAX &&
                    !(wb_valid && wb_rd == issue_rd);
  assign stall    = issue_valid && ((issue_use_rs && w_rs_hit) || (issue_use_rt && w_rt_hit) || w_full);
  assign w_inc    = issue_valid && !stall && issue_wr_en && issue_rd != '0;
  assign w_dec    = wb_valid && wb_rd != '0 && r_cnt[wb_rd] != '0;
  assign w_ill    = wb_valid && wb_rd != '0 && r_cnt[wb_rd] == '0 && !(w_inc && issue_rd == wb_rd);
  assign w_inc_oh = {{(N-1){1'b0}}, w_inc} << issue_rd;
  assign w_dec_oh = {{(N-1){1'b0}}, w_dec} << wb_rd;
  assign busy     = r_busy;
  assign err      = r_err;
  // per-register next count; a same-register issue and retire cancel out
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_nxt[i]      = (w_inc_oh[i] && !w_dec_oh[i]) ? r_cnt[i] + ONE :
                      (w_dec_oh[i] && !w_inc_oh[i]) ? r_cnt[i] - ONE : r_cnt[i];
      w_busy_nxt[i] = w_nxt[i] != '0;
    end
  end
  // counter, busy and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) r_cnt[i] <= w_nxt[i];
      r_busy <= w_busy_nxt;
      r_err  <= r_err | w_ill;
    end
  end
endmodule
